// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// master: operand producer and result consumer; slave: the adder.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor. One GROUP_W-bit CLA group is
// resolved per stage; the inter-group carry and the not-yet-added upper
// operand bits travel down the pipe with a valid/ready handshake per stage.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned GROUP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned GROUPS = WIDTH / GROUP_W;

  if ((WIDTH < GROUP_W) || ((WIDTH % GROUP_W) != 0)) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP_W");
  end

  // Group look-ahead: every carry is a sum of products of g/p and the group
  // carry-in, so no carry ripples bit to bit. Returns {carry_out, sum}.
  function automatic logic [GROUP_W:0] cla_group(
    input logic [GROUP_W-1:0] x,
    input logic [GROUP_W-1:0] y,
    input logic               c0
  );
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W:0]   c;
    logic               pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    pp   = 1'b0;
    for (int unsigned i = 0; i < GROUP_W; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int unsigned j = 0; j < i; j++) begin
        c[i+1] = c[i+1] | (pp & g[i-1-j]);
        pp     = pp & p[i-1-j];
      end
      c[i+1] = c[i+1] | (pp & c0);
    end
    return {c[GROUP_W], p ^ c[GROUP_W-1:0]};
  endfunction

  logic [GROUPS-1:0] vld;
  logic [GROUPS-1:0] rdy;
  logic              full_tail;

  // Stage k may load when empty or when everything below it can move;
  // equivalently, unless it and all later stages are full and out_ready=0.
  always_comb begin
    rdy       = '0;
    full_tail = 1'b1;
    for (int unsigned i = 0; i < GROUPS; i++) begin
      full_tail           = full_tail & vld[GROUPS-1-i];
      rdy[GROUPS-1-i]     = bus.out_ready | ~full_tail;
    end
  end

  assign bus.in_ready = rdy[0];

  for (genvar k = 0; k < GROUPS; k++) begin : stg
    localparam int unsigned IN_W = WIDTH - k * GROUP_W;
    localparam int unsigned REM  = IN_W - GROUP_W;
    localparam int unsigned DONE = (k + 1) * GROUP_W;

    logic [IN_W-1:0]  pa;
    logic [IN_W-1:0]  pb;
    logic             pc;
    logic             up_valid;
    logic [GROUP_W:0] grp;
    logic [DONE-1:0]  s_d;
    logic [DONE-1:0]  s_q;
    logic             c_q;
    logic             valid_q;

    if (k == 0) begin : src
      // Subtraction folds into the first stage as a + ~b + ~cin.
      assign pa       = bus.a;
      assign pb       = bus.sub ? ~bus.b : bus.b;
      assign pc       = bus.sub ? ~bus.cin : bus.cin;
      assign up_valid = bus.in_valid;
      assign s_d      = grp[GROUP_W-1:0];
    end else begin : src
      assign pa       = stg[k-1].rem.a_q;
      assign pb       = stg[k-1].rem.b_q;
      assign pc       = stg[k-1].c_q;
      assign up_valid = stg[k-1].valid_q;
      assign s_d      = {grp[GROUP_W-1:0], stg[k-1].s_q};
    end

    assign grp    = cla_group(pa[GROUP_W-1:0], pb[GROUP_W-1:0], pc);
    assign vld[k] = valid_q;

    // Stage register: valid, resolved low sum bits and group carry-out;
    // held unchanged while the stage is stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        s_q     <= '0;
      end else if (rdy[k]) begin
        valid_q <= up_valid;
        if (up_valid) begin
          c_q <= grp[GROUP_W];
          s_q <= s_d;
        end
      end
    end

    if (REM > 0) begin : rem
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      // Unprocessed upper operand bits, right-aligned for the next group.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k] && up_valid) begin
          a_q <= pa[IN_W-1:GROUP_W];
          b_q <= pb[IN_W-1:GROUP_W];
        end
      end
    end

    if (k == GROUPS - 1) begin : last
      logic ovf_q;

      // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (rdy[k] && up_valid) begin
          ovf_q <= grp[GROUP_W] ^ grp[GROUP_W-1] ^ pa[GROUP_W-1] ^ pb[GROUP_W-1];
        end
      end

      assign bus.out_valid = valid_q;
      assign bus.sum       = s_q;
      assign bus.cout      = c_q;
      assign bus.ovf       = ovf_q;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=8, GROUP_W=4).
module tb_pipelined_cla_adder;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned GROUP_W = 4;
  localparam int unsigned GROUPS  = WIDTH / GROUP_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP_W(GROUP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    int unsigned cyc;
  } res_t;

  res_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          blocked_cnt = 0;
  bit          lat_check = 1'b0;
  bit          held_valid = 1'b0;
  bit          accepted = 1'b0;
  logic [7:0]  held_sum;
  logic        held_cout;
  logic        ordy = 1'b1;
  bit          tbl_use = 1'b0;
  logic [7:0]  tbl_sum;
  logic        tbl_cout;
  logic        tbl_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add/subtract; cout = carry (add) or no-borrow (sub).
  function automatic res_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic ci, input logic s);
    res_t r;
    int   ua = int'(x);
    int   ub = int'(y);
    int   sa = int'($signed(x));
    int   sb = int'($signed(y));
    int   u;
    int   sv;
    if (!s) begin
      u      = ua + ub + int'(ci);
      sv     = sa + sb + int'(ci);
      r.cout = (u > 255);
    end else begin
      u      = ua - ub - int'(ci);
      sv     = sa - sb - int'(ci);
      r.cout = (u >= 0);
    end
    r.sum = u[7:0];
    r.ovf = (sv > 127) || (sv < -128);
    r.cyc = 0;
    return r;
  endfunction

  task automatic observe();
    res_t r;
    accepted = 1'b0;
    check("in_ready", {31'd0, bus.in_ready},
          (exp_q.size() >= GROUPS && !bus.out_ready) ? 32'd0 : 32'd1);
    if (!bus.in_ready) blocked_cnt++;
    if (bus.out_valid) begin
      if (held_valid) begin
        check("stall_sum", {24'd0, bus.sum}, {24'd0, held_sum});
        check("stall_cout", {31'd0, bus.cout}, {31'd0, held_cout});
      end
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, bus.out_valid}, 32'd0);
      end else if (!held_valid && lat_check) begin
        check("latency", cyc - exp_q[0].cyc, 32'd2);
      end
      if (bus.out_ready) begin
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check("sum", {24'd0, bus.sum}, {24'd0, r.sum});
          check("cout", {31'd0, bus.cout}, {31'd0, r.cout});
          check("ovf", {31'd0, bus.ovf}, {31'd0, r.ovf});
        end
        held_valid = 1'b0;
      end else begin
        held_valid = 1'b1;
        held_sum   = bus.sum;
        held_cout  = bus.cout;
      end
    end else if (held_valid) begin
      check("stall_drop", {31'd0, bus.out_valid}, 32'd1);
      held_valid = 1'b0;
    end
    if (bus.in_valid && bus.in_ready) begin
      if (tbl_use) begin
        r.sum  = tbl_sum;
        r.cout = tbl_cout;
        r.ovf  = tbl_ovf;
      end else begin
        r = model(bus.a, bus.b, bus.cin, bus.sub);
      end
      r.cyc = cyc;
      exp_q.push_back(r);
      accepted = 1'b1;
    end
  endtask

  // Called just after a falling edge; inputs settle, then the upcoming
  // rising edge is scored, then returns at the next falling edge.
  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input logic is);
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.cin       = ic;
    bus.sub       = is;
    bus.out_ready = ordy;
    #2;
    observe();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
    int tries = 0;
    do begin
      step(1'b1, ia, ib, ic, is);
      tries++;
    end while (!accepted && tries < 40);
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_tbl(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic is, input logic [7:0] es, input logic ec, input logic eo);
    tbl_use  = 1'b1;
    tbl_sum  = es;
    tbl_cout = ec;
    tbl_ovf  = eo;
    send(ia, ib, ic, is);
    tbl_use  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] oa[5];
    logic [7:0] ob[5];
    int         idx;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", {24'd0, bus.sum}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // Directed add/sub cases with fixed expectations, no stalls.
    lat_check = 1'b1;
    ordy      = 1'b1;
    send_tbl(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
    idle(3);
    send_tbl(8'hFC, 8'h16, 1'b1, 1'b0, 8'h13, 1'b1, 1'b0);
    send_tbl(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send_tbl(8'h08, 8'h02, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0);
    send_tbl(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    send_tbl(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    idle(4);
    check("directed_drain", exp_q.size(), 32'd0);

    // Back-pressure: five ops, out_ready low for 4 cycles from first out_valid.
    lat_check   = 1'b0;
    blocked_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      oa[i] = 8'($urandom);
      ob[i] = 8'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 40 && (idx < 5 || exp_q.size() > 0); c++) begin
      ordy = !(c >= 2 && c < 6);
      if (idx < 5) step(1'b1, oa[idx], ob[idx], 1'($urandom), 1'($urandom));
      else         step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      if (accepted) idx++;
    end
    check("bp_all_accepted", idx, 32'd5);
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_saw_block", {31'd0, blocked_cnt > 0}, 32'd1);
    ordy = 1'b1;

    // Bubble collapse: stage 2 stalled, stage 1 empty.
    send(8'h11, 8'h22, 1'b0, 1'b0);
    idle(1);
    ordy = 1'b0;
    step(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
    check("bubble_accept", {31'd0, accepted}, 32'd1);
    step(1'b1, 8'h55, 8'h66, 1'b0, 1'b1);
    check("full_block", {31'd0, accepted}, 32'd0);
    ordy = 1'b1;
    send(8'h55, 8'h66, 1'b0, 1'b1);
    idle(4);
    check("bubble_drain", exp_q.size(), 32'd0);

    // Asynchronous reset with two operations in flight.
    send(8'hAA, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 8'h02, 1'b0, 1'b0);
    check("rst_two_in_flight", {31'd0, accepted}, 32'd1);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_sum", {24'd0, bus.sum}, 32'd0);
    exp_q.delete();
    held_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    lat_check = 1'b1;
    send_tbl(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    idle(3);
    check("post_rst_drain", exp_q.size(), 32'd0);

    // Random traffic with random back-pressure.
    lat_check = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ordy = ($urandom_range(0, 9) < 7);
      step(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
    end
    ordy = 1'b1;
    idle(6);
    check("final_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
